// File: rtl/p1.sv
// p1: registered 4-input function; q loads TRUTH_TABLE[{a,b,c,d}] on each rising edge.
module p1 #(
   parameter logic [15:0] TRUTH_TABLE = 16'hEEE0
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic q
);
   logic [3:0] w_idx;
   logic       w_f;
   logic       r_q;
   assign w_idx = {a, b, c, d};
   assign w_f   = TRUTH_TABLE[w_idx];
   always_ff @(posedge clk)
      r_q <= rst ? 1'b0 : w_f;
   assign q = r_q;
endmodule

// File: tb/tb_p1.sv
// tb_p1: table-driven checks of p1 with default and single-minterm tables via a one-deep scoreboard.
module tb_p1;
   logic clk = 1'b0;
   logic rst, a, b, c, d;
   logic q_def, q_and;
   int   n_cmp = 0;
   int   n_bad = 0;

   typedef struct {
      logic       rst;
      logic [3:0] in;
      logic       e_def;
      logic       e_and;
      string      name;
   } vec_t;

   vec_t tv[$];
   vec_t sb[$];

   p1 u_def (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .q(q_def));
   p1 #(.TRUTH_TABLE(16'h8000)) u_and (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .q(q_and));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [3:0] v, input string name);
      vec_t t;
      t.rst   = r;
      t.in    = v;
      t.e_def = r ? 1'b0 : ((v[3] | v[2]) & (v[1] | v[0]));
      t.e_and = r ? 1'b0 : (v == 4'b1111);
      t.name  = name;
      return t;
   endfunction

   task automatic drive(input vec_t t);
      rst = t.rst;
      {a, b, c, d} = t.in;
      sb.push_back(t);
   endtask

   task automatic settle();
      vec_t t;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard: got empty queue expected one entry");
      end else begin
         t = sb.pop_front();
         chk({t.name, "/def"}, q_def, t.e_def);
         chk({t.name, "/and"}, q_and, t.e_and);
      end
   endtask

   initial begin
      tv.push_back(mk(1'b1, 4'b1111, "reset0"));
      tv.push_back(mk(1'b1, 4'b1111, "reset1"));
      for (int i = 0; i < 16; i++) tv.push_back(mk(1'b0, 4'(i), $sformatf("sweep%0d", i)));
      tv.push_back(mk(1'b0, 4'd4, "lat4"));
      tv.push_back(mk(1'b0, 4'd5, "lat5"));
      tv.push_back(mk(1'b0, 4'd0, "lat0"));
      rst = 1'b1;
      {a, b, c, d} = 4'b1111;
      #1;
      foreach (tv[i]) begin
         drive(tv[i]);
         settle();
      end
      if (q_def !== 1'b0) $display("FAIL spot0000: got %b expected 0", q_def);
      // Mid-run reset: q must hold until the reset edge, then recover immediately.
      drive(mk(1'b0, 4'b1111, "mid_pre"));
      settle();
      drive(mk(1'b1, 4'b1111, "mid_rst"));
      #2;
      chk("mid_hold_def", q_def, 1'b1);
      chk("mid_hold_and", q_and, 1'b1);
      settle();
      drive(mk(1'b0, 4'b1111, "mid_rel"));
      settle();
      // Glitch immunity: d toggles between edges, settles to 0 before sampling.
      drive(mk(1'b0, 4'b1000, "glitch"));
      #1 d = 1'b1;
      #1 chk("glitch_hold_hi", q_def, 1'b1);
      d = 1'b0;
      #1 d = 1'b1;
      #1 d = 1'b0;
      settle();
      #2 d = 1'b1;
      #1 chk("glitch_between", q_def, 1'b0);
      d = 1'b0;
      drive(mk(1'b0, 4'b1000, "glitch_next"));
      settle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish expected completion");
      $fatal(1, "timeout");
   end
endmodule
